// File: rtl/red_cord_cut_latch_pkg.sv
// rtl/red_cord_cut_latch_pkg.sv - shared types and defaults for the red cord cut latch
package red_cord_pkg;

    typedef enum logic [2:0] {
        SAFE     = 3'd0,
        HOLDOFF  = 3'd1,
        ARM_WAIT = 3'd2,
        RELEASE  = 3'd3,
        RUN      = 3'd4
    } rc_state_t;

    localparam int HOLDOFF_CYCLES_DEF = 1000;
    localparam int RELEASE_CYCLES_DEF = 50;
    localparam int CNT_W_DEF          = 16;
    localparam int TRIP_CNT_W         = 8;

    // Clear scene: comparator allows motion and nobody is in the cell.
    function automatic logic scene_clear(input logic motor_enable, input logic presence);
        return motor_enable & ~presence;
    endfunction

endpackage

// File: rtl/red_cord_cut_latch_if.sv
// rtl/red_cord_cut_latch_if.sv - veto inputs and power/brake outputs of the cut latch
interface red_cord_cut_latch_if;
    import red_cord_pkg::*;

    logic                  motor_enable_in;
    logic                  human_presence_sensor;
    logic                  rearm_req;
    logic                  power_enable;
    logic                  brake_engage;
    logic                  veto_latched;
    logic [TRIP_CNT_W-1:0] trip_count;

    modport master (
        output motor_enable_in, human_presence_sensor, rearm_req,
        input  power_enable, brake_engage, veto_latched, trip_count
    );

    modport slave (
        input  motor_enable_in, human_presence_sensor, rearm_req,
        output power_enable, brake_engage, veto_latched, trip_count
    );

endinterface

// File: rtl/red_cord_cut_latch_holdoff_timer.sv
// rtl/red_cord_cut_latch_holdoff_timer.sv - loadable down-counter shared by hold-off and release
module red_cord_holdoff_timer #(
    parameter int               CNT_W       = 16,
    parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] load_value,
    input  logic             load,
    input  logic             dec,
    output logic             at_one
);

    logic [CNT_W-1:0] count;

    // Load wins over decrement; the count parks at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign at_one = (count == CNT_W'(1));

endmodule

// File: rtl/red_cord_cut_latch.sv
// rtl/red_cord_cut_latch.sv - latches any veto into a power cut and sequences operator re-arm
module red_cord_cut_latch
    import red_cord_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
    parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    red_cord_cut_latch_if.slave  bus
);

    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    if (HOLDOFF_CYCLES < 1 || longint'(HOLDOFF_CYCLES) > CNT_MAX) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES out of range for CNT_W");
    end
    if (RELEASE_CYCLES < 1 || longint'(RELEASE_CYCLES) > CNT_MAX) begin : g_bad_release
        $error("RELEASE_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] REL_LD  = CNT_W'(RELEASE_CYCLES);

    rc_state_t             state;
    logic                  rearm_q;
    logic                  power_q;
    logic                  brake_q;
    logic                  veto_q;
    logic [TRIP_CNT_W-1:0] trip_q;

    logic             clear;
    logic             rearm_edge;
    logic             trip;
    logic             load;
    logic             dec;
    logic [CNT_W-1:0] load_value;
    logic             at_one;

    // Presence only trips in RELEASE; once running, the comparator owns that call.
    always_comb begin
        clear      = scene_clear(bus.motor_enable_in, bus.human_presence_sensor);
        rearm_edge = bus.rearm_req & ~rearm_q;
        trip       = ((state == RELEASE) && !clear) ||
                     ((state == RUN) && !bus.motor_enable_in);
        load       = 1'b0;
        dec        = 1'b0;
        load_value = HOLD_LD;
        case (state)
            SAFE:     load = 1'b1;
            HOLDOFF:  if (clear) dec = 1'b1; else load = 1'b1;
            ARM_WAIT: begin
                if (!clear) begin
                    load = 1'b1;
                end else if (rearm_edge) begin
                    load       = 1'b1;
                    load_value = REL_LD;
                end
            end
            RELEASE:  if (trip) load = 1'b1; else dec = 1'b1;
            RUN:      if (trip) load = 1'b1;
            default:  load = 1'b1;
        endcase
    end

    red_cord_holdoff_timer #(
        .CNT_W       (CNT_W),
        .RESET_VALUE (HOLD_LD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_value (load_value),
        .load       (load),
        .dec        (dec),
        .at_one     (at_one)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= SAFE;
            rearm_q <= 1'b1;
            power_q <= 1'b0;
            brake_q <= 1'b1;
            veto_q  <= 1'b1;
            trip_q  <= '0;
        end else begin
            rearm_q <= bus.rearm_req;
            if (trip) begin
                state   <= SAFE;
                power_q <= 1'b0;
                brake_q <= 1'b1;
                veto_q  <= 1'b1;
                if (trip_q != '1) begin
                    trip_q <= trip_q + 1'b1;
                end
            end else begin
                case (state)
                    SAFE: begin
                        state   <= HOLDOFF;
                        power_q <= 1'b0;
                        brake_q <= 1'b1;
                        veto_q  <= 1'b1;
                    end
                    HOLDOFF: begin
                        if (clear && at_one) begin
                            state <= ARM_WAIT;
                        end
                    end
                    ARM_WAIT: begin
                        if (!clear) begin
                            state <= HOLDOFF;
                        end else if (rearm_edge) begin
                            state   <= RELEASE;
                            power_q <= 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (at_one) begin
                            state   <= RUN;
                            brake_q <= 1'b0;
                            veto_q  <= 1'b0;
                        end
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    default: begin
                        state   <= SAFE;
                        power_q <= 1'b0;
                        brake_q <= 1'b1;
                        veto_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.power_enable = power_q;
    assign bus.brake_engage = brake_q;
    assign bus.veto_latched = veto_q;
    assign bus.trip_count   = trip_q;

endmodule

// File: doc/red_cord_cut_latch.md
# red_cord_cut_latch

Latching power-cut sequencer directly downstream of the Red Cord veto comparator. It consumes the comparator's `motor_enable` verdict and turns any veto, even a single cycle, into a latched power cut with brake engagement. Release requires a hold-off period, a clear scene and an explicit operator re-arm edge, followed by an ordered power-then-brake release. The AI path has no input to this block.

## Interface
Parameters:
- `HOLDOFF_CYCLES`, 1000: clear-scene cycles required before re-arm is accepted; legal range 1..2^CNT_W-1.
- `RELEASE_CYCLES`, 50: cycles between `power_enable` rising and `brake_engage` falling; legal range 1..2^CNT_W-1.
- `CNT_W`, 16: width of the shared down-counter.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `motor_enable_in`  in  1  veto verdict from the comparator; 0 = veto.
- `human_presence_sensor`  in  1  1 = human detected; already synchronous to `clk`.
- `rearm_req`  in  1  operator re-arm button, level; only its rising edge counts.
- `power_enable`  out  1  motor driver power; 1 = energised.
- `brake_engage`  out  1  mechanical brake; 1 = engaged.
- `veto_latched`  out  1  1 whenever state is not RUN.
- `trip_count`  out  8  saturating count of veto trips since reset.

## Operation
- States: SAFE (reset/entry), HOLDOFF, ARM_WAIT, RELEASE, RUN. All outputs are registered.
- Reset (`rst_n`=0 at a clock edge): state SAFE, `power_enable`=0, `brake_engage`=1, `veto_latched`=1, `trip_count`=0, counter loaded with HOLDOFF_CYCLES, edge-detect history set to 1.
  - Reset asserted mid-RELEASE or mid-RUN forces the same values on that edge.
- SAFE: `power_enable`=0, `brake_engage`=1. Moves unconditionally to HOLDOFF next cycle with the counter loaded to HOLDOFF_CYCLES.
- HOLDOFF: the counter decrements each cycle that `motor_enable_in`=1 and `human_presence_sensor`=0.
  - Either condition failing reloads the counter to HOLDOFF_CYCLES.
  - Counter at 1 with a clear scene moves to ARM_WAIT.
- ARM_WAIT: waits for a `rearm_req` rising edge (sampled 0 then 1) coinciding with `motor_enable_in`=1 and `human_presence_sensor`=0.
  - When all three hold: `power_enable` goes to 1, counter loads RELEASE_CYCLES, state moves to RELEASE.
  - Scene not clear: return to HOLDOFF with the counter reloaded.
  - A `rearm_req` held high across entry into ARM_WAIT is not an edge; the operator must release and press again.
- RELEASE: `power_enable`=1, `brake_engage`=1, counter decrements. Counter at 1 moves to RUN with `brake_engage` going to 0.
- Trip: in RELEASE or RUN, `motor_enable_in`=0 or `human_presence_sensor`=1 sampled at an edge causes the following on that same edge:
  - state moves to SAFE, `power_enable`=0, `brake_engage`=1;
  - `trip_count` increments, saturating at 255.
  - In RUN, `human_presence_sensor` alone does not trip; the comparator owns that decision. In RELEASE, presence does trip.
- Priority: reset > trip > re-arm > counter.
- Trips are counted only from RELEASE or RUN. Vetoes seen in SAFE, HOLDOFF or ARM_WAIT only reload the counter.

## Timing
- Veto to cut latency: `motor_enable_in` sampled 0 at edge N gives `power_enable`=0 and `brake_engage`=1 after edge N. That is one clock, with no combinational path.
- A single-cycle veto pulse is latched; it never self-clears.
- Minimum time from trip to `power_enable`=1: 1 (SAFE) + HOLDOFF_CYCLES + 1 (re-arm edge) cycles.
- `brake_engage` falls exactly RELEASE_CYCLES edges after `power_enable` rises, absent a trip.
- Power is never 0 while the brake is released. Both are updated on the same edge, and the cut edge drives both.

## Structure
- Package `red_cord_pkg` holds:
  - the `rc_state_t` enum (SAFE, HOLDOFF, ARM_WAIT, RELEASE, RUN);
  - default constants for HOLDOFF_CYCLES and RELEASE_CYCLES;
  - `TRIP_CNT_W`=8.
- Sub-module `red_cord_holdoff_timer`: a CNT_W down-counter with load value, load strobe, decrement enable and an `at_one` flag. It is shared by HOLDOFF and RELEASE.
- Parameter range checks are elaboration-time assertions.

## Test plan
Benches use HOLDOFF_CYCLES=8 and RELEASE_CYCLES=4.
- Reset, clear scene, `rearm_req` pulse at cycle 12 -> `power_enable`=1 at cycle 13, `brake_engage`=0 at cycle 17, `veto_latched`=0, `trip_count`=0.
- From RUN, 1-cycle `motor_enable_in`=0 -> `power_enable`=0 and `brake_engage`=1 on the next edge; they stay cut after the veto clears; `trip_count`=1.
- Human present at cycle 5 of HOLDOFF -> counter reloads; ARM_WAIT is reached only after 8 further clear cycles.
- `rearm_req` held high from reset through ARM_WAIT -> no release. Drop to 0, then raise -> release proceeds.
- Veto in RELEASE at counter=2 -> SAFE, brake never releases, `trip_count` increments. 300 forced trips -> `trip_count`=255.
- `rst_n`=0 for one edge during RUN -> SAFE outputs on that edge, `trip_count`=0, full hold-off required again.
